jtpang_objdma: RTL and testbench
================================

# jtpang_objdma

Object DMA controller that owns the DMA side of the shared video RAM. When triggered, typically at vertical blank, it requests the CPU bus and waits for the grant. It then reads the 512-byte object table from the upper VRAM half through the DMA address port and writes it into the double-buffered object line buffer. It sits between the CPU bus arbitration logic, the tile/VRAM block and the object renderer.

## Interface
Parameters:
- OBJW, 9, width of the object-table byte address: 128 objects × 4 bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; every state change and output update happens only on clk edges with cen=1
- dma_go  in  1  transfer request, sampled on cen; a level held for several cens counts as one request
- busrq_n  out  1  CPU bus request, active low
- busak_n  in  1  CPU bus acknowledge, active low; also steers VRAM addressing to dma_addr
- dma_addr  out  9  VRAM object-table byte address: [8:2] object, [1:0] byte
- vram_dout  in  8  VRAM read data; valid one clk after dma_addr changes
- obj_addr  out  9  object buffer write address
- obj_din  out  8  object buffer write data
- obj_we  out  1  object buffer write strobe, one cen wide per byte
- obj_bank  out  1  buffer half being written; the renderer reads ~obj_bank
- busy  out  1  high from request acceptance until the bus is released

## Operation
The controller has four states: IDLE, REQ, COPY and REL.
- **IDLE:** busrq_n=1, busy=0. A rising edge of dma_go, or a pending flag, moves the state to REQ and clears the pending flag.
- **REQ:** busrq_n=0, busy=1, dma_addr=0. The state waits for busak_n=0 with no timeout. On grant it moves to COPY.
- **COPY:** each cen with busak_n=0 does two things:
  - it increments dma_addr;
  - it writes the byte read on the previous cen: obj_we=1, obj_addr = previous dma_addr, obj_din = vram_dout.
- **Copy write sequence:**
  - The first cen of COPY only issues address 0, so obj_we=0 on that cen.
  - After address 511 is issued, one more cen writes byte 511. The state then moves to REL.
  - dma_addr wraps to 0 at that point.
- **Grant withdrawn mid-COPY:** if busak_n returns to 1 during COPY, the transfer pauses.
  - dma_addr and the internal write pointer are held and obj_we=0.
  - On the first cen after busak_n returns to 0, the controller re-issues the held address and does not write.
  - The next cen resumes writing, so no byte is lost or duplicated.
- **REL:** busrq_n=1. The state waits for busak_n=1, then does three things:
  - toggles obj_bank;
  - drops busy;
  - moves to IDLE.
- **Requests while busy:** a dma_go rising edge while busy=1 sets a single pending flag. Multiple edges collapse into one pending flag. The pending transfer starts on the cen after returning to IDLE.
- **Width rules:** dma_addr is a 9-bit counter. obj_addr always equals dma_addr delayed by one accepted COPY cen.

## Timing
- **Reset values:** busrq_n=1, dma_addr=0, obj_addr=0, obj_din=0, obj_we=0, obj_bank=0, busy=0, state IDLE, pending flag cleared.
- **Reset mid-transfer:** asserting rst_n=0 at any point returns all outputs to these values immediately.
- **Request latency:** the dma_go edge is seen on cen n. busrq_n=0 and busy=1 from cen n+1.
- **Grant latency:** busak_n=0 is sampled on cen g. Address 0 is issued on cen g+1, and the first obj_we occurs on cen g+2.
- **Transfer length:** COPY lasts 513 accepted cens, including the first address-only cen and the final write-only cen.
- **End of copy:** busrq_n=1 on the cen after the last write.
- **Release:** obj_bank toggles and busy falls on the first cen at which busak_n=1 is sampled in REL.
- **Minimum period:** with a zero-delay grant and release, go to busy-low spans 516 cens.
- **cen cadence:** vram_dout only needs to be stable one clk after the address change, so cen may be asserted on every clk.

## Test plan
- **Basic copy:** preload VRAM object half with byte[i]=i[7:0]^8'h5A, cen every clk, grant 1 cen after request. Required: 512 writes with buffer[i]=i[7:0]^8'h5A, obj_bank 0→1, busy high for 516 cens.
- **Slow grant:** hold busak_n=1 for 20 cens after busrq_n falls. Required: dma_addr stays 0, no obj_we, then the copy is correct; first write 2 cens after the grant.
- **Grant withdrawn:** raise busak_n for 7 cens after byte 100 is written. Required: no writes during the gap; byte 101 is the next write; all 512 bytes are correct, none duplicated.
- **Queued requests:** pulse dma_go 3 times during COPY. Required: exactly one extra transfer after REL→IDLE; obj_bank ends at 0 after two transfers.
- **Mid-copy reset:** assert rst_n=0 at byte 300, release, then trigger. Required: all outputs return to their reset values during reset; the new transfer writes bank 0 starting at address 0.
- **Sparse cen:** cen 1-in-4 clks. Required: same buffer contents as the basic copy; 513 COPY cens = 2052 clks.

Source files
------------

// File: rtl/jtpang_objdma.sv
`default_nettype none
// ============================================================================
// Module   : jtpang_objdma
// Purpose  : Object DMA controller. On a dma_go request it asks for the CPU
//            bus, and once the bus is granted it copies the 512-byte object
//            table from the upper VRAM half into the write half of the
//            double-buffered object line buffer. It then releases the bus and
//            swaps the buffer halves.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   cen            clock enable; all state and outputs advance only on cen
//   dma_go         transfer request (rising edge, sampled on cen)
//   busrq_n        CPU bus request (active low)
//   busak_n        CPU bus acknowledge (active low)
//   dma_addr       VRAM object-table byte address
//   vram_dout      VRAM read data for dma_addr
//   obj_addr       object buffer write address
//   obj_din        object buffer write data
//   obj_we         object buffer write strobe (one cen per byte)
//   obj_bank       buffer half being written; the renderer reads ~obj_bank
//   busy           high from request acceptance until the bus is released
// ============================================================================
module jtpang_objdma #(
    parameter int OBJW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            dma_go,
    output logic            busrq_n,
    input  logic            busak_n,
    output logic [OBJW-1:0] dma_addr,
    input  logic [7:0]      vram_dout,
    output logic [OBJW-1:0] obj_addr,
    output logic [7:0]      obj_din,
    output logic            obj_we,
    output logic            obj_bank,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COPY = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    localparam logic [OBJW-1:0] LAST_ADDR = '1;

    state_t          state_q,    state_d;
    logic            busrq_n_q,  busrq_n_d;
    logic [OBJW-1:0] dma_addr_q, dma_addr_d;
    logic [OBJW-1:0] obj_addr_q, obj_addr_d;
    logic [7:0]      obj_din_q,  obj_din_d;
    logic            obj_we_q,   obj_we_d;
    logic            obj_bank_q, obj_bank_d;
    logic            busy_q,     busy_d;
    logic            pend_q,     pend_d;
    logic            go_prev_q,  go_prev_d;
    // primed: the address on dma_addr has been presented for a full accepted
    // cen while the bus was granted, so vram_dout now holds its data.
    logic            primed_q,   primed_d;
    logic            go_edge;

    always_comb begin
        state_d    = state_q;
        busrq_n_d  = busrq_n_q;
        dma_addr_d = dma_addr_q;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        obj_we_d   = 1'b0;
        obj_bank_d = obj_bank_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        primed_d   = primed_q;
        go_prev_d  = dma_go;
        go_edge    = dma_go & ~go_prev_q;

        // Any number of requests during a transfer collapse into one.
        if (go_edge && busy_q) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go_edge || pend_q) begin
                    state_d    = ST_REQ;
                    busrq_n_d  = 1'b0;
                    busy_d     = 1'b1;
                    dma_addr_d = '0;
                    pend_d     = 1'b0;
                end
            end
            ST_REQ: begin
                if (!busak_n) begin
                    state_d  = ST_COPY;
                    primed_d = 1'b0;
                end
            end
            ST_COPY: begin
                if (busak_n) begin
                    // Bus taken away: hold the address, and require one
                    // address-only cen after the grant returns because the
                    // VRAM was not addressed by us meanwhile.
                    primed_d = 1'b0;
                end else if (!primed_q) begin
                    primed_d = 1'b1;
                end else begin
                    obj_we_d   = 1'b1;
                    obj_addr_d = dma_addr_q;
                    obj_din_d  = vram_dout;
                    dma_addr_d = dma_addr_q + OBJW'(1);
                    if (dma_addr_q == LAST_ADDR) begin
                        state_d   = ST_REL;
                        busrq_n_d = 1'b1;
                        primed_d  = 1'b0;
                    end
                end
            end
            ST_REL: begin
                if (busak_n) begin
                    state_d    = ST_IDLE;
                    obj_bank_d = ~obj_bank_q;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busrq_n_q  <= 1'b1;
            dma_addr_q <= '0;
            obj_addr_q <= '0;
            obj_din_q  <= 8'd0;
            obj_we_q   <= 1'b0;
            obj_bank_q <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            go_prev_q  <= 1'b0;
            primed_q   <= 1'b0;
        end else if (cen) begin
            state_q    <= state_d;
            busrq_n_q  <= busrq_n_d;
            dma_addr_q <= dma_addr_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            obj_we_q   <= obj_we_d;
            obj_bank_q <= obj_bank_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            go_prev_q  <= go_prev_d;
            primed_q   <= primed_d;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign dma_addr = dma_addr_q;
    assign obj_addr = obj_addr_q;
    assign obj_din  = obj_din_q;
    assign obj_we   = obj_we_q;
    assign obj_bank = obj_bank_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpang_objdma.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtpang_objdma
// Purpose  : Self-checking bench for jtpang_objdma. A VRAM model, a CPU bus
//            arbiter model and a write monitor surround the DUT; each test
//            task compares the captured object buffer and timing against
//            values derived from the transfer rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtpang_objdma;

    logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0, dma_go = 1'b0, busak_n = 1'b1;
    logic [7:0] vram_dout;
    logic       busrq_n, obj_we, obj_bank, busy;
    logic [8:0] dma_addr, obj_addr;
    logic [7:0] obj_din;

    int total = 0, bad = 0;

    logic [7:0] mem [512];
    logic [7:0] junk = 8'd0;
    logic [7:0] bufm [2][512];
    int         wcount [512];

    int cen_div = 1, cen_ph = 0;
    int grant_delay = 0, gwait = 0, wd_left = 0;
    bit wd_arm = 0, after_gap = 0, granted = 0;
    int after_gap_addr = -1, last_addr = -1;
    int cen_idx = 0, clk_idx = 0, xfer_wr = 0, next_addr = 0;
    int order_err = 0, gap_wr = 0, wait_err = 0, rises = 0, dones = 0;
    int rise_cen = 0, fall_cen = 0, grant_cen = 0, grant_clk = 0;
    int first_we_cen = 0, last_we_clk = 0, first_wr_addr = -1, wr_bank = -1;
    bit exp_bank = 0;
    logic s_cen, s_bak, s_busy;

    jtpang_objdma #(.OBJW(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .dma_go    (dma_go),
        .busrq_n   (busrq_n),
        .busak_n   (busak_n),
        .dma_addr  (dma_addr),
        .vram_dout (vram_dout),
        .obj_addr  (obj_addr),
        .obj_din   (obj_din),
        .obj_we    (obj_we),
        .obj_bank  (obj_bank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cen_ph = (cen_ph + 1) % cen_div;
        cen    = (cen_ph == 0);
        junk   = 8'($urandom);
    end

    // VRAM object half: addressed by dma_addr only while the bus is granted.
    assign vram_dout = busak_n ? junk : mem[dma_addr];

    // Write monitor and CPU bus arbiter model.
    always @(posedge clk) begin
        s_cen = cen; s_bak = busak_n; s_busy = busy;
        #1;
        clk_idx++;
        if (s_cen) begin
            cen_idx++;
            if (!s_busy && busy) begin
                rises++; rise_cen = cen_idx; granted = 0; xfer_wr = 0; next_addr = 0;
                for (int i = 0; i < 512; i++) wcount[i] = 0;
            end
            if (s_busy && !busy) begin dones++; fall_cen = cen_idx; end
            if (s_busy && !s_bak && !granted) begin
                granted = 1; grant_cen = cen_idx; grant_clk = clk_idx;
            end
            if (busy && !granted && (dma_addr != 9'd0 || obj_we)) wait_err++;
            if (obj_we) begin
                if (s_bak) gap_wr++;
                if (xfer_wr == 0) begin
                    first_we_cen = cen_idx; first_wr_addr = int'(obj_addr); wr_bank = int'(obj_bank);
                end
                if (int'(obj_addr) != next_addr) order_err++;
                next_addr = int'(obj_addr) + 1;
                bufm[obj_bank][obj_addr] = obj_din;
                wcount[obj_addr]++;
                xfer_wr++; last_we_clk = clk_idx; last_addr = int'(obj_addr);
                if (after_gap) begin after_gap = 0; after_gap_addr = int'(obj_addr); end
            end
            if (wd_arm && obj_we && obj_addr == 9'd100) begin
                wd_arm = 0; wd_left = 7; busak_n = 1'b1;
            end else if (wd_left > 0) begin
                wd_left--;
                if (wd_left == 0) begin busak_n = 1'b0; after_gap = 1; end
            end else if (!busrq_n && busak_n) begin
                if (gwait >= grant_delay) begin busak_n = 1'b0; gwait = 0; end
                else gwait++;
            end else if (busrq_n && !busak_n) begin
                busak_n = 1'b1;
            end
        end
    end

    function automatic int bad_bytes(input int bank);
        int n = 0;
        for (int i = 0; i < 512; i++)
            if (wcount[i] != 1 || bufm[bank][i] !== mem[i]) n++;
        return n;
    endfunction

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < 512; i++)
            mem[i] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; dma_go = 1'b0; busak_n = 1'b1;
        gwait = 0; wd_arm = 0; wd_left = 0; after_gap = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        exp_bank = 0;
    endtask

    task automatic trigger();
        int n = 0;
        @(negedge clk); dma_go = 1'b1;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        @(negedge clk); dma_go = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, output bit to);
        int n = 0;
        while (dones < target && n < limit) begin @(negedge clk); n++; end
        to = (dones < target);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busrq_n, dma_addr, obj_addr, obj_din, obj_we, obj_bank, busy} !==
            {1'b1, 9'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_hold got=%b want=1 0 0 0 0 0 0",
                            {busrq_n, dma_addr, obj_addr, obj_din, obj_we, obj_bank, busy});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busrq_n, busy, obj_we} !== 3'b100) begin
            bad++; $display("FAIL reset_idle got=%b want=100", {busrq_n, busy, obj_we});
        end
    endtask

    task automatic test_basic();
        bit to; int d0; bit b0;
        fill_mem(1); grant_delay = 0; order_err = 0; d0 = dones; b0 = exp_bank;
        trigger(); wait_done(d0 + 1, 3000, to);
        exp_bank = ~exp_bank;
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=%0d want=%0d", dones, d0 + 1); end
        total++; if (wr_bank != int'(b0)) begin bad++; $display("FAIL basic_wrbank got=%0d want=%0d", wr_bank, b0); end
        total++; if (bad_bytes(int'(b0)) != 0) begin bad++; $display("FAIL basic_data got=%0d bad bytes want=0", bad_bytes(int'(b0))); end
        total++; if (xfer_wr != 512) begin bad++; $display("FAIL basic_count got=%0d want=512", xfer_wr); end
        total++; if (obj_bank !== exp_bank) begin bad++; $display("FAIL basic_bank got=%b want=%b", obj_bank, exp_bank); end
        total++; if (fall_cen - rise_cen + 1 != 516) begin bad++; $display("FAIL basic_span got=%0d want=516", fall_cen - rise_cen + 1); end
        total++; if (first_we_cen - grant_cen != 2) begin bad++; $display("FAIL basic_first_we got=%0d want=2", first_we_cen - grant_cen); end
        total++; if (order_err != 0) begin bad++; $display("FAIL basic_order got=%0d want=0", order_err); end
    endtask

    task automatic test_slow_grant();
        bit to; int d0; bit b0;
        fill_mem(0); grant_delay = 20; wait_err = 0; order_err = 0; d0 = dones; b0 = exp_bank;
        trigger(); wait_done(d0 + 1, 3000, to);
        grant_delay = 0; exp_bank = ~exp_bank;
        total++; if (to) begin bad++; $display("FAIL slow_timeout got=%0d want=%0d", dones, d0 + 1); end
        total++; if (wait_err != 0) begin bad++; $display("FAIL slow_wait got=%0d want=0", wait_err); end
        total++; if (grant_cen - rise_cen != 21) begin bad++; $display("FAIL slow_grant got=%0d want=21", grant_cen - rise_cen); end
        total++; if (first_we_cen - grant_cen != 2) begin bad++; $display("FAIL slow_first_we got=%0d want=2", first_we_cen - grant_cen); end
        total++; if (bad_bytes(int'(b0)) != 0 || order_err != 0) begin bad++; $display("FAIL slow_data got=%0d want=0", bad_bytes(int'(b0)) + order_err); end
        total++; if (obj_bank !== exp_bank) begin bad++; $display("FAIL slow_bank got=%b want=%b", obj_bank, exp_bank); end
    endtask

    task automatic test_withdraw();
        bit to; int d0; bit b0;
        fill_mem(0); gap_wr = 0; order_err = 0; after_gap_addr = -1; d0 = dones; b0 = exp_bank;
        wd_arm = 1;
        trigger(); wait_done(d0 + 1, 3000, to);
        exp_bank = ~exp_bank;
        total++; if (to) begin bad++; $display("FAIL wd_timeout got=%0d want=%0d", dones, d0 + 1); end
        total++; if (gap_wr != 0) begin bad++; $display("FAIL wd_gap_writes got=%0d want=0", gap_wr); end
        total++; if (after_gap_addr != 101) begin bad++; $display("FAIL wd_resume got=%0d want=101", after_gap_addr); end
        total++; if (xfer_wr != 512 || order_err != 0) begin bad++; $display("FAIL wd_count got=%0d/%0d want=512/0", xfer_wr, order_err); end
        total++; if (bad_bytes(int'(b0)) != 0) begin bad++; $display("FAIL wd_data got=%0d want=0", bad_bytes(int'(b0))); end
    endtask

    task automatic test_queued();
        bit to; int d0, r0, n;
        reset_dut();
        fill_mem(0); d0 = dones; r0 = rises; n = 0;
        trigger();
        while (xfer_wr < 50 && n < 300) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); dma_go = 1'b1;
            @(negedge clk); dma_go = 1'b0;
        end
        wait_done(d0 + 2, 4000, to);
        total++; if (to) begin bad++; $display("FAIL queue_timeout got=%0d want=%0d", dones, d0 + 2); end
        total++; if (rises - r0 != 2) begin bad++; $display("FAIL queue_xfers got=%0d want=2", rises - r0); end
        total++; if (obj_bank !== 1'b0) begin bad++; $display("FAIL queue_bank got=%b want=0", obj_bank); end
        total++; if (bad_bytes(1) != 0) begin bad++; $display("FAIL queue_data got=%0d want=0", bad_bytes(1)); end
        repeat (700) @(negedge clk);
        total++; if (rises - r0 != 2) begin bad++; $display("FAIL queue_extra got=%0d want=2", rises - r0); end
    endtask

    task automatic test_mid_reset();
        bit to; int d0, n;
        fill_mem(0); last_addr = -1; n = 0;
        trigger();
        while (last_addr != 300 && n < 1000) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #2;
        total++;
        if ({busrq_n, dma_addr, obj_addr, obj_din, obj_we, obj_bank, busy} !==
            {1'b1, 9'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_outputs got=%b want=1 0 0 0 0 0 0",
                            {busrq_n, dma_addr, obj_addr, obj_din, obj_we, obj_bank, busy});
        end
        reset_dut();
        fill_mem(0); d0 = dones;
        trigger(); wait_done(d0 + 1, 3000, to);
        exp_bank = 1;
        total++; if (to) begin bad++; $display("FAIL midrst_timeout got=%0d want=%0d", dones, d0 + 1); end
        total++; if (first_wr_addr != 0 || wr_bank != 0) begin bad++; $display("FAIL midrst_start got=addr %0d bank %0d want=addr 0 bank 0", first_wr_addr, wr_bank); end
        total++; if (bad_bytes(0) != 0) begin bad++; $display("FAIL midrst_data got=%0d want=0", bad_bytes(0)); end
        total++; if (obj_bank !== 1'b1) begin bad++; $display("FAIL midrst_bank got=%b want=1", obj_bank); end
    endtask

    task automatic test_sparse();
        bit to; int d0; bit b0;
        cen_div = 4; fill_mem(1); order_err = 0; d0 = dones; b0 = exp_bank;
        trigger(); wait_done(d0 + 1, 6000, to);
        exp_bank = ~exp_bank;
        total++; if (to) begin bad++; $display("FAIL sparse_timeout got=%0d want=%0d", dones, d0 + 1); end
        total++; if (bad_bytes(int'(b0)) != 0 || xfer_wr != 512) begin bad++; $display("FAIL sparse_data got=%0d bad, %0d writes want=0, 512", bad_bytes(int'(b0)), xfer_wr); end
        total++; if (last_we_clk - grant_clk != 2052) begin bad++; $display("FAIL sparse_clks got=%0d want=2052", last_we_clk - grant_clk); end
        total++; if (first_we_cen - grant_cen != 2) begin bad++; $display("FAIL sparse_first_we got=%0d want=2", first_we_cen - grant_cen); end
        total++; if (obj_bank !== exp_bank) begin bad++; $display("FAIL sparse_bank got=%b want=%b", obj_bank, exp_bank); end
        cen_div = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_grant();
        test_withdraw();
        test_queued();
        test_mid_reset();
        test_sparse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
